// File: rtl/mux_scan_sel.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_sel
//  Purpose  : Registered N-channel, W-bit-per-channel selector with three
//             modes: DIRECT (switch select), SCAN (automatic round-robin with
//             a programmable dwell time) and HOLD (freeze).
//
//  Ports
//    clk           in   1          system clock, rising edge
//    rst_n         in   1          asynchronous active-low reset
//    i_data        in   N*W        packed channels, channel k at [k*W +: W]
//    i_mux_select  in   SEL_W      channel index used in DIRECT mode
//    i_mode        in   2          00 DIRECT, 01 SCAN, 10 HOLD, 11 as HOLD
//    i_dwell       in   DWELL_W    SCAN presents each channel Dwell+1 cycles
//    o_out         out  W          registered selected channel data
//    o_channel     out  SEL_W      index of the channel shown on o_out
//    o_valid       out  1          o_out holds legal channel data
//    o_wrap        out  1          one-cycle pulse on SCAN step N-1 -> 0
//
//  Revision : 1.0  initial release
// ============================================================================
module mux_scan_sel #(
  parameter int N       = 7,
  parameter int W       = 1,
  parameter int DWELL_W = 4,
  localparam int SEL_W  = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W-1:0]     i_data,
  input  logic [SEL_W-1:0]   i_mux_select,
  input  logic [1:0]         i_mode,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [W-1:0]       o_out,
  output logic [SEL_W-1:0]   o_channel,
  output logic               o_valid,
  output logic               o_wrap
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // One extra bit so that N itself is representable when N is a power of two.
  localparam logic [SEL_W:0]   c_N_EXT = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] c_LAST  = SEL_W'(N-1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [W-1:0]       r_out;
  logic [SEL_W-1:0]   r_chan;
  logic               r_valid;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_dwell_cnt;
  mode_e              r_prev_mode;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  logic [W-1:0]       w_out_nxt;
  logic [SEL_W-1:0]   w_chan_nxt;
  logic               w_valid_nxt;
  logic               w_wrap_nxt;
  logic [DWELL_W-1:0] w_dwell_nxt;
  mode_e              w_mode;
  logic [SEL_W-1:0]   w_scan_next;
  logic               w_sel_legal;

  // Pick channel idx out of the packed bus; out-of-range indices yield zero
  // so the output never carries x.
  function automatic logic [W-1:0] f_pick(input logic [N*W-1:0] data,
                                          input logic [SEL_W-1:0] idx);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SEL_W'(k)) begin
        v = data[k*W +: W];
      end
    end
    return v;
  endfunction

  assign w_mode      = mode_e'(i_mode);
  assign w_sel_legal = ({1'b0, i_mux_select} < c_N_EXT);
  // >= rather than == keeps the scan inside 0..N-1 for non-power-of-two N.
  assign w_scan_next = (r_chan >= c_LAST) ? '0 : r_chan + SEL_W'(1);

  always_comb begin
    w_out_nxt   = r_out;
    w_chan_nxt  = r_chan;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;
    w_dwell_nxt = r_dwell_cnt;

    case (w_mode)
      MODE_DIRECT: begin
        w_chan_nxt  = i_mux_select;
        w_dwell_nxt = '0;
        if (w_sel_legal) begin
          w_out_nxt   = f_pick(i_data, i_mux_select);
          w_valid_nxt = 1'b1;
        end else begin
          w_out_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      end

      MODE_SCAN: begin
        w_valid_nxt = 1'b1;
        if (r_prev_mode != MODE_SCAN) begin
          // Fresh entry always restarts the sweep at channel 0, no wrap.
          w_chan_nxt  = '0;
          w_dwell_nxt = '0;
          w_out_nxt   = f_pick(i_data, '0);
        end else if (r_dwell_cnt >= i_dwell) begin
          // >= so that lowering the dwell mid-count advances immediately
          // instead of counting all the way around the counter.
          w_dwell_nxt = '0;
          w_chan_nxt  = w_scan_next;
          w_out_nxt   = f_pick(i_data, w_scan_next);
          w_wrap_nxt  = (w_scan_next == '0);
        end else begin
          w_dwell_nxt = r_dwell_cnt + DWELL_W'(1);
          // Keep tracking live changes on the presented channel.
          w_out_nxt   = f_pick(i_data, r_chan);
        end
      end

      default: begin
        // HOLD and reserved: everything frozen, wrap stays low.
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_chan      <= '0;
      r_valid     <= 1'b0;
      r_wrap      <= 1'b0;
      r_dwell_cnt <= '0;
      r_prev_mode <= MODE_HOLD;
    end else begin
      r_out       <= w_out_nxt;
      r_chan      <= w_chan_nxt;
      r_valid     <= w_valid_nxt;
      r_wrap      <= w_wrap_nxt;
      r_dwell_cnt <= w_dwell_nxt;
      r_prev_mode <= w_mode;
    end
  end

  assign o_out     = r_out;
  assign o_channel = r_chan;
  assign o_valid   = r_valid;
  assign o_wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_sel
//  Purpose  : Directed self-checking bench for mux_scan_sel. Instance A is
//             N=7, W=1 for DIRECT checks; instance B is N=7, W=4 with each
//             channel carrying its own index for SCAN/HOLD/reset checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_scan_sel;

  logic clk;
  logic rst_n;

  // Instance A (W=1)
  logic [6:0]  dA;
  logic [2:0]  selA;
  logic [1:0]  modeA;
  logic [3:0]  dwellA;
  logic [0:0]  outA;
  logic [2:0]  chA;
  logic        vA;
  logic        wA;

  // Instance B (W=4)
  logic [27:0] dB;
  logic [2:0]  selB;
  logic [1:0]  modeB;
  logic [3:0]  dwellB;
  logic [3:0]  outB;
  logic [2:0]  chB;
  logic        vB;
  logic        wB;

  int n_checks;
  int n_fail;

  mux_scan_sel #(.N(7), .W(1), .DWELL_W(4)) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (dA),
    .i_mux_select (selA),
    .i_mode       (modeA),
    .i_dwell      (dwellA),
    .o_out        (outA),
    .o_channel    (chA),
    .o_valid      (vA),
    .o_wrap       (wA)
  );

  mux_scan_sel #(.N(7), .W(4), .DWELL_W(4)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (dB),
    .i_mux_select (selB),
    .i_mode       (modeB),
    .i_dwell      (dwellB),
    .o_out        (outB),
    .o_channel    (chB),
    .o_valid      (vB),
    .o_wrap       (wB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int wrap_cnt;
  int last_wrap;
  int wrap_period;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    dA = 7'b1010110; selA = 3'd0; modeA = 2'b10; dwellA = 4'd0;
    for (int k = 0; k < 7; k++) dB[k*4 +: 4] = 4'(k);
    selB = 3'd0; modeB = 2'b10; dwellB = 4'd0;

    #2;
    check("rst_out",   32'(outB), 32'd0);
    check("rst_chan",  32'(chB),  32'd0);
    check("rst_valid", 32'(vB),   32'd0);
    check("rst_wrap",  32'(wB),   32'd0);
    check("rst_valid_a", 32'(vA), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---------------- DIRECT (instance A) ----------------
    modeA = 2'b00; selA = 3'd2;
    tick();
    check("dir_out_s2",   32'(outA), 32'd1);
    check("dir_chan_s2",  32'(chA),  32'd2);
    check("dir_valid_s2", 32'(vA),   32'd1);
    selA = 3'd7;
    tick();
    check("dir_out_s7",   32'(outA), 32'd0);
    check("dir_chan_s7",  32'(chA),  32'd7);
    check("dir_valid_s7", 32'(vA),   32'd0);
    selA = 3'd0;
    tick();
    check("dir_out_s0",   32'(outA), 32'd0);
    check("dir_valid_s0", 32'(vA),   32'd1);
    selA = 3'd6;
    tick();
    check("dir_out_s6",   32'(outA), 32'd1);
    check("dir_wrap_a",   32'(wA),   32'd0);

    // ---------------- SCAN dwell 0 (instance B) ----------------
    modeB = 2'b01; dwellB = 4'd0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("scan0_chan", 32'(chB),  32'(i % 7));
      check("scan0_out",  32'(outB), 32'(i % 7));
      check("scan0_wrap", 32'(wB),   32'(i == 7));
    end

    // ---------------- SCAN dwell 2 ----------------
    modeB = 2'b00; selB = 3'd3;
    tick();
    check("dir_b_chan", 32'(chB), 32'd3);
    modeB = 2'b01; dwellB = 4'd2;
    wrap_cnt = 0; last_wrap = -1; wrap_period = 0;
    for (int i = 0; i < 44; i++) begin
      tick();
      check("scan2_chan", 32'(chB), 32'((i / 3) % 7));
      check("scan2_wrap", 32'(wB),  32'((i % 21 == 0) && (i != 0)));
      if (wB) begin
        if (last_wrap >= 0) wrap_period = i - last_wrap;
        last_wrap = i;
        wrap_cnt++;
      end
    end
    check("scan2_wrap_cnt",    32'(wrap_cnt),    32'd2);
    check("scan2_wrap_period", 32'(wrap_period), 32'd21);

    // ---------------- Dwell lowered 9 -> 1 at count 5 ----------------
    modeB = 2'b00;
    tick();
    modeB = 2'b01; dwellB = 4'd9;
    tick();
    check("dl_entry_chan", 32'(chB), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("dl_hold_chan", 32'(chB), 32'd0);
      if (i == 3) dB[3:0] = 4'd9;
      if (i == 4) begin
        check("dl_live_track", 32'(outB), 32'd9);
        dB[3:0] = 4'd0;
      end
    end
    dwellB = 4'd1;
    for (int j = 0; j < 6; j++) begin
      tick();
      check("dl_chan", 32'(chB), 32'(1 + j / 2));
    end

    // ---------------- HOLD mid channel 3, then SCAN ----------------
    modeB = 2'b00;
    tick();
    modeB = 2'b01; dwellB = 4'd2;
    for (int i = 0; i <= 10; i++) tick();
    check("pre_hold_chan", 32'(chB), 32'd3);
    modeB = 2'b10;
    dB[15:12] = 4'hC;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_out",   32'(outB), 32'd3);
      check("hold_chan",  32'(chB),  32'd3);
      check("hold_valid", 32'(vB),   32'd1);
      check("hold_wrap",  32'(wB),   32'd0);
    end
    dB[15:12] = 4'd3;
    modeB = 2'b11;
    tick();
    check("rsvd_chan", 32'(chB), 32'd3);
    modeB = 2'b01;
    tick();
    check("resume_chan", 32'(chB),  32'd0);
    check("resume_out",  32'(outB), 32'd0);
    check("resume_wrap", 32'(wB),   32'd0);

    // ---------------- Async reset mid-scan ----------------
    dwellB = 4'd0;
    tick();
    tick();
    tick();
    check("pre_rst_chan", 32'(chB),  32'd3);
    check("pre_rst_out",  32'(outB), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out",   32'(outB), 32'd0);
    check("arst_chan",  32'(chB),  32'd0);
    check("arst_valid", 32'(vB),   32'd0);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_chan",  32'(chB),  32'd0);
    check("post_rst_valid", 32'(vB),   32'd1);
    check("post_rst_wrap",  32'(wB),   32'd0);
    tick();
    check("post_rst_next",  32'(chB),  32'd1);
    check("post_rst_out",   32'(outB), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
